// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and default width.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_full_adder_hs.sv
// Full-adder cell built from two XOR/AND half adders, with an OR merging their carries.
module full_adder_hs (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs1_s;
  logic hs1_c;
  logic hs2_c;

  assign hs1_s = x ^ y;
  assign hs1_c = x & y;

  assign s     = hs1_s ^ ci;
  assign hs2_c = hs1_s & ci;

  assign co    = hs1_c | hs2_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// LSB-first bit-serial adder: one full-adder cell, WIDTH RUN cycles per add, one-cycle done pulse.
// Defining SERIAL_ADD_OVF_EN adds a signed-overflow output ovf, held with sum/cout.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one bit per cycle through the full-adder cell
// DONE  | sum/cout (and ovf) just updated; done pulses; start here reloads directly
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             sbit;
  logic             cbit;
  logic             load;
  logic             step;
  logic             last;

  full_adder_hs u_fa (
    .x  (shift_a[0]),
    .y  (shift_b[0]),
    .ci (carry),
    .s  (sbit),
    .co (cbit)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;

  // Signed overflow: carry into the MSB (current carry) versus carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (step && last) begin
      ovf_q <= carry ^ cbit;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_a <= '0;
      shift_b <= '0;
      res     <= '0;
      sum_q   <= '0;
      carry   <= 1'b0;
      cout_q  <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      shift_a <= a;
      shift_b <= b;
      carry   <= cin;
      cnt     <= '0;
    end else if (step) begin
      shift_a <= shift_a >> 1;
      shift_b <= shift_b >> 1;
      carry   <= cbit;
      res     <= {sbit, res[WIDTH-1:1]};
      cnt     <= cnt + CW'(1);
      // Published result only changes on DONE entry so it holds through IDLE and RUN.
      if (last) begin
        sum_q  <= {sbit, res[WIDTH-1:1]};
        cout_q <= cbit;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed corner cases plus random adds against an arithmetic model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  // Called at posedge+1; returns one time unit after the accepting edge.
  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    start = 1'b1;
    a     = xa;
    b     = xb;
    cin   = xc;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  task automatic observe(output int lat, output int busy_n, output int dones,
                         output logic [W-1:0] s_o, output logic c_o, output logic v_o);
    lat = 0; busy_n = 0; dones = 0; s_o = '0; c_o = 1'b0; v_o = 1'b0;
    for (int c = 1; c <= W + 3; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        dones++;
        if (lat == 0) begin
          lat = c;
          s_o = sum;
          c_o = cout;
`ifdef SERIAL_ADD_OVF_EN
          v_o = ovf;
`endif
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h expected 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat, bn, dn; logic [W-1:0] s; logic c, v;
    issue(8'h03, 8'h05, 1'b0);
    observe(lat, bn, dn, s, c, v);
    checks++; if (lat !== W + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, W + 1); end
    checks++; if (bn !== W) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bn, W); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", dn); end
    checks++; if (s !== 8'h08) begin errors++; $display("FAIL basic_sum: got %h expected 08", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b expected 0", c); end
    checks++; if (sum !== 8'h08) begin errors++; $display("FAIL basic_sum_held: got %h expected 08", sum); end
  endtask

  task automatic test_carry();
    logic [W-1:0] ta [2] = '{8'hFF, 8'hFF};
    logic [W-1:0] tb [2] = '{8'h01, 8'h00};
    logic         tc [2] = '{1'b0, 1'b1};
    int lat, bn, dn; logic [W-1:0] s; logic c, v;
    for (int i = 0; i < 2; i++) begin
      issue(ta[i], tb[i], tc[i]);
      observe(lat, bn, dn, s, c, v);
      checks++; if (s !== 8'h00) begin errors++; $display("FAIL carry_sum[%0d]: got %h expected 00", i, s); end
      checks++; if (c !== 1'b1) begin errors++; $display("FAIL carry_cout[%0d]: got %b expected 1", i, c); end
      checks++; if (lat !== W + 1) begin errors++; $display("FAIL carry_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
    end
  endtask

  task automatic test_ignore_start();
    int lat, bn, dn; logic [W-1:0] s; logic c, v;
    issue(8'h21, 8'h42, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; a = 8'h10; b = 8'h10; cin = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    observe(lat, bn, dn, s, c, v);
    checks++; if (s !== 8'h63) begin errors++; $display("FAIL ignore_sum: got %h expected 63", s); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL ignore_done_pulses: got %0d expected 1", dn); end
    checks++; if (lat !== W - 3) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", lat, W - 3); end
  endtask

  task automatic test_mid_reset();
    int lat, bn, dn; logic [W-1:0] s; logic c, v;
    int late_dones = 0;
    issue(8'h5A, 8'h33, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL midrst_sum: got %h expected 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout: got %b expected 0", cout); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done || busy) late_dones++;
    end
    checks++; if (late_dones !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", late_dones); end
    @(posedge clk);
    #1;
    issue(8'h12, 8'h34, 1'b0);
    observe(lat, bn, dn, s, c, v);
    checks++; if (s !== 8'h46 || lat !== W + 1) begin errors++; $display("FAIL midrst_fresh: got sum=%h lat=%0d expected 46 %0d", s, lat, W + 1); end
  endtask

  task automatic test_back_to_back();
    int lat, bn, dn; logic [W-1:0] s; logic c, v;
    issue(8'h03, 8'h05, 1'b0);
    repeat (W) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1 || sum !== 8'h08) begin errors++; $display("FAIL b2b_first: got done=%b sum=%h expected 1 08", done, sum); end
    start = 1'b1; a = 8'h0A; b = 8'h14; cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_no_idle: got busy=%b done=%b expected 1 0", busy, done); end
    repeat (3) @(negedge clk);
    checks++; if (sum !== 8'h08) begin errors++; $display("FAIL b2b_held: got %h expected 08", sum); end
    observe(lat, bn, dn, s, c, v);
    checks++; if (s !== 8'h1E || c !== 1'b0) begin errors++; $display("FAIL b2b_second: got %h/%b expected 1e/0", s, c); end
    checks++; if (lat !== W - 2 || dn !== 1) begin errors++; $display("FAIL b2b_timing: got lat=%0d dones=%0d expected %0d 1", lat, dn, W - 2); end
  endtask

  task automatic test_random();
    int lat, bn, dn; logic [W-1:0] s; logic c, v;
    logic [W-1:0] ra, rb; logic rc; logic [W:0] exp;
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      exp = ref_add(ra, rb, rc);
      issue(ra, rb, rc);
      observe(lat, bn, dn, s, c, v);
      checks++;
      if (s !== exp[W-1:0] || c !== exp[W] || lat !== W + 1 || dn !== 1) begin
        errors++;
        $display("FAIL rand[%0d] %h+%h+%b: got sum=%h cout=%b lat=%0d dones=%0d expected %h %b %0d 1",
                 i, ra, rb, rc, s, c, lat, dn, exp[W-1:0], exp[W], W + 1);
      end
`ifdef SERIAL_ADD_OVF_EN
      checks++;
      if (v !== ref_ovf(ra, rb, exp[W-1:0])) begin
        errors++;
        $display("FAIL rand_ovf[%0d]: got %b expected %b", i, v, ref_ovf(ra, rb, exp[W-1:0]));
      end
`endif
    end
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf();
    int lat, bn, dn; logic [W-1:0] s; logic c, v;
    issue(8'h7F, 8'h01, 1'b0);
    observe(lat, bn, dn, s, c, v);
    checks++; if (s !== 8'h80 || v !== 1'b1 || c !== 1'b0) begin errors++; $display("FAIL ovf_pos: got sum=%h ovf=%b cout=%b expected 80 1 0", s, v, c); end
    issue(8'h80, 8'hFF, 1'b0);
    observe(lat, bn, dn, s, c, v);
    checks++; if (s !== 8'h7F || v !== 1'b1 || c !== 1'b1) begin errors++; $display("FAIL ovf_neg: got sum=%h ovf=%b cout=%b expected 7f 1 1", s, v, c); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_held: got %b expected 1", ovf); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
`ifdef SERIAL_ADD_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
